// File: rtl/nn_quant_pkg.sv
// Shared neuron-layer definitions: accumulator defaults, sequencer states and
// the requantize/ReLU/saturate step used by every node flavour.
package nn_quant_pkg;

    localparam int DEF_ACC_W      = 23;
    localparam int DEF_FRAC_SHIFT = 6;

    typedef enum logic [1:0] {S_IDLE, S_BIAS, S_MAC, S_QUANT} seq_state_e;

    // acc must arrive sign-extended to 64 bits; fs >= 1.
    // Round half up on bit fs-1, clamp negatives to 0 and large values to 127.
    function automatic logic [7:0] quantize(input logic [63:0] acc, input int fs);
        logic [63:0] half;
        logic [63:0] sh;
        logic [7:0]  r;
        half = acc >> (fs - 1);
        sh   = half >> 1;
        r    = {1'b0, sh[6:0]} + {7'b0, half[0]};
        if (acc[63])
            quantize = 8'd0;
        else if (sh[63:7] != '0 || r[7])
            quantize = 8'd127;
        else
            quantize = r;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered signed 8x8 multiply-accumulate; load_bias seeds the accumulator
// with the bias plus the first product, accumulate adds subsequent products.
module mac_unit
    import nn_quant_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_bias,
    input  logic                    accumulate,
    input  logic signed [7:0]       a,
    input  logic signed [7:0]       w,
    input  logic signed [15:0]      bias,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] prod_x;
    logic signed [ACC_W-1:0] bias_x;

    assign prod   = 16'(a) * 16'(w);
    assign prod_x = {{(ACC_W-16){prod[15]}}, prod};
    assign bias_x = {{(ACC_W-16){bias[15]}}, bias};

    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (load_bias)
            acc <= bias_x + prod_x;
        else if (accumulate)
            acc <= acc + prod_x;
    end

endmodule

// File: rtl/layer_seq_ctrl.sv
// Time-multiplexed layer sequencer: walks N_OUT neurons through one shared MAC,
// fetching bias/weights/activations from 1-cycle-latency memories.
module layer_seq_ctrl
    import nn_quant_pkg::*;
#(
    parameter int N_IN       = 15,
    parameter int N_OUT      = 32,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    output logic                            busy,
    output logic [$clog2(N_IN)-1:0]         act_addr,
    input  logic signed [7:0]               act_data,
    output logic [$clog2(N_IN*N_OUT)-1:0]   w_addr,
    input  logic signed [7:0]               w_data,
    output logic [$clog2(N_OUT)-1:0]        b_addr,
    input  logic signed [15:0]              b_data,
    output logic                            out_valid,
    output logic [$clog2(N_OUT)-1:0]        out_idx,
    output logic [7:0]                      out_data,
    output logic                            done
);

    localparam int AW = $clog2(N_IN);
    localparam int WW = $clog2(N_IN*N_OUT);
    localparam int BW = $clog2(N_OUT);
    localparam logic [AW-1:0] K_LAST = AW'(N_IN - 1);
    localparam logic [AW-1:0] K_PEN  = AW'(N_IN - 2);
    localparam logic [BW-1:0] N_LAST = BW'(N_OUT - 1);

    seq_state_e              state;
    logic [BW-1:0]           n;
    logic [AW-1:0]           k;
    logic signed [ACC_W-1:0] acc;
    logic [63:0]             acc_x;
    logic                    load_bias;
    logic                    accumulate;

    assign b_addr     = n;
    assign load_bias  = (state == S_MAC) && (k == '0);
    assign accumulate = (state == S_MAC) && (k != '0);
    assign acc_x      = {{(64-ACC_W){acc[ACC_W-1]}}, acc};

    mac_unit #(.ACC_W(ACC_W)) u_mac (
        .clk        (clk),
        .reset      (reset),
        .load_bias  (load_bias),
        .accumulate (accumulate),
        .a          (act_data),
        .w          (w_data),
        .bias       (b_data),
        .acc        (acc)
    );

    // w_addr runs contiguously across neurons, so the base n*N_IN never needs a multiply.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            n         <= '0;
            k         <= '0;
            act_addr  <= '0;
            w_addr    <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= start;
                    if (start) begin
                        state    <= S_BIAS;
                        n        <= '0;
                        act_addr <= '0;
                        w_addr   <= '0;
                    end
                end
                S_BIAS: begin
                    state    <= S_MAC;
                    k        <= '0;
                    act_addr <= AW'(1);
                    w_addr   <= w_addr + WW'(1);
                end
                S_MAC: begin
                    if (k == K_LAST) begin
                        state <= S_QUANT;
                    end else begin
                        k <= k + AW'(1);
                        // addresses lead k by one; stop once the last operand is issued
                        if (k != K_PEN) begin
                            act_addr <= act_addr + AW'(1);
                            w_addr   <= w_addr + WW'(1);
                        end
                    end
                end
                S_QUANT: begin
                    out_data  <= quantize(acc_x, FRAC_SHIFT);
                    out_idx   <= n;
                    out_valid <= 1'b1;
                    if (n == N_LAST) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        n        <= n + BW'(1);
                        act_addr <= '0;
                        w_addr   <= w_addr + WW'(1);
                        state    <= S_BIAS;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Self-checking bench: cycle-indexed expectation tables built from the
// dot-product/rounding rules, compared against the DUT every cycle.
module tb_layer_seq_ctrl;

    localparam int N_IN   = 15;
    localparam int N_OUT  = 32;
    localparam int FS     = 6;
    localparam int STRIDE = N_IN + 2;
    localparam int LAYER  = N_OUT * STRIDE + 1;
    localparam int MAXC   = 16384;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, out_valid, done;
    logic [3:0] act_addr;
    logic [8:0] w_addr;
    logic [4:0] b_addr, out_idx;
    logic [7:0] out_data;
    logic signed [7:0]  act_data, w_data;
    logic signed [15:0] b_data;

    logic signed [7:0]  act_mem [N_IN];
    logic signed [7:0]  w_mem   [N_IN*N_OUT];
    logic signed [15:0] b_mem   [N_OUT];

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int free_edge = 0;
    int last_base = 0;
    bit exp_busy [MAXC];
    bit exp_v    [MAXC];
    bit exp_done [MAXC];
    int exp_idx  [MAXC];
    int exp_data [MAXC];

    int obs_cnt, obs_first, obs_done, obs_done_idx;
    int obs_data [N_OUT];
    int obs_idx0 [$];

    layer_seq_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .act_addr(act_addr), .act_data(act_data),
        .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data),
        .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        act_data <= act_mem[act_addr];
        w_data   <= w_mem[w_addr];
        b_data   <= b_mem[b_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int model_q(input int acc);
        int q;
        if (acc < 0) return 0;
        q = (acc + (1 << (FS - 1))) >>> FS;
        return (q > 127) ? 127 : q;
    endfunction

    // Reference: cycle c = spec cycle (c - base) of a layer whose start edge is spec edge 0.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            for (int c = cyc; c < MAXC; c++) begin
                exp_busy[c] = 1'b0; exp_v[c] = 1'b0; exp_done[c] = 1'b0;
            end
            free_edge = cyc + 1;
        end else if (start && cyc >= free_edge && cyc + LAYER < MAXC) begin
            last_base = cyc - 1;
            free_edge = cyc + LAYER;
            for (int c = 1; c <= LAYER; c++) exp_busy[last_base + c] = 1'b1;
            for (int n = 0; n < N_OUT; n++) begin
                int acc, t;
                acc = int'(b_mem[n]);
                for (int k = 0; k < N_IN; k++)
                    acc += int'(act_mem[k]) * int'(w_mem[n*N_IN + k]);
                t = last_base + (n + 1) * STRIDE + 1;
                exp_v[t] = 1'b1; exp_idx[t] = n; exp_data[t] = model_q(acc);
            end
            exp_done[last_base + LAYER] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0 && cyc < MAXC) begin
            check("busy", int'(busy), int'(exp_busy[cyc]));
            check("out_valid", int'(out_valid), int'(exp_v[cyc]));
            check("done", int'(done), int'(exp_done[cyc]));
            if (exp_v[cyc]) begin
                check("out_idx", int'(out_idx), exp_idx[cyc]);
                check("out_data", int'(out_data), exp_data[cyc]);
            end
            if (out_valid === 1'b1) begin
                obs_cnt++;
                obs_data[out_idx] = int'(out_data);
                if (obs_cnt == 1) obs_first = cyc;
                if (out_idx == 5'd0) obs_idx0.push_back(cyc);
                if (done === 1'b1) begin obs_done = cyc; obs_done_idx = int'(out_idx); end
            end
        end
    end

    task automatic clear_obs();
        obs_cnt = 0; obs_first = -1; obs_done = -1; obs_done_idx = -1;
        obs_idx0.delete();
        for (int n = 0; n < N_OUT; n++) obs_data[n] = -1;
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < N_IN; k++)
            case (mode)
                2: act_mem[k] = 8'sd64;
                4: act_mem[k] = 8'sd127;
                5: act_mem[k] = -8'sd1;
                6: act_mem[k] = 8'($urandom_range(0, 255));
                default: act_mem[k] = 8'sd0;
            endcase
        for (int i = 0; i < N_IN*N_OUT; i++)
            case (mode)
                2, 5: w_mem[i] = 8'sd1;
                4: w_mem[i] = 8'sd127;
                6: w_mem[i] = 8'(int'($urandom_range(0, 15)) - 8);
                default: w_mem[i] = 8'($urandom_range(0, 255));
            endcase
        for (int n = 0; n < N_OUT; n++)
            case (mode)
                1: b_mem[n] = -16'sd1024;
                3: b_mem[n] = 16'sd32;
                6: b_mem[n] = 16'(int'($urandom_range(0, 4095)) - 2048);
                default: b_mem[n] = 16'sd0;
            endcase
    endtask

    task automatic run_layer(input bit pulses);
        int b;
        @(negedge clk);
        clear_obs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b = last_base;
        if (pulses) begin
            while (cyc < b + 100) @(negedge clk);
            start = 1'b1; @(negedge clk); start = 1'b0;
            while (cyc < b + 333) @(negedge clk);
            start = 1'b1; @(negedge clk); start = 1'b0;
        end
        while (cyc < b + LAYER + 5) @(negedge clk);
    endtask

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int b1;
        fill(6);
        clear_obs();
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_addrs", int'(act_addr) + int'(w_addr) + int'(b_addr), 0);
        reset = 1'b0;

        fill(1); run_layer(1'b0);
        check("t1_count", obs_cnt, N_OUT);
        check("t1_data0", obs_data[0], 0);
        check("t1_data_last", obs_data[N_OUT-1], 0);
        check("t1_done_cycle", obs_done - last_base, 545);
        check("t1_done_idx", obs_done_idx, N_OUT - 1);

        fill(2); run_layer(1'b0);
        check("t2_first_cycle", obs_first - last_base, 18);
        check("t2_data0", obs_data[0], 15);
        check("t2_data_last", obs_data[N_OUT-1], 15);

        fill(3); run_layer(1'b0);
        check("t3_round", obs_data[7], 1);

        fill(4); run_layer(1'b0);
        check("t4_sat", obs_data[3], 127);

        fill(5); run_layer(1'b0);
        check("t5_neg", obs_data[9], 0);

        repeat (3) begin
            fill(6); run_layer(1'b1);
            check("rand_count", obs_cnt, N_OUT);
        end

        // back-to-back layers with start held high
        fill(6);
        @(negedge clk);
        clear_obs();
        start = 1'b1;
        @(negedge clk);
        b1 = last_base;
        while (cyc < b1 + LAYER + 25) @(negedge clk);
        start = 1'b0;
        while (cyc < b1 + 2*LAYER + 5) @(negedge clk);
        check("b2b_count", obs_cnt, 2 * N_OUT);
        check("b2b_idx0_pulses", obs_idx0.size(), 2);
        if (obs_idx0.size() == 2) check("b2b_second_idx0", obs_idx0[1] - b1, 545 + 18);

        // reset during MAC of neuron 3
        fill(6);
        @(negedge clk);
        clear_obs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b1 = last_base;
        while (cyc < b1 + 58) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_rst_count", obs_cnt, 3);
        check("mid_rst_no_idx3", obs_data[3], -1);
        run_layer(1'b0);
        check("post_rst_count", obs_cnt, N_OUT);
        check("post_rst_first", obs_first - last_base, 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_seq_ctrl.md
# layer_seq_ctrl

Time-multiplexed neuron layer sequencer. It computes N_OUT neurons of N_IN inputs each on one shared signed 8x8 multiply-accumulate unit. It fetches activations, weights and biases from synchronous memories and emits one requantized, ReLU-saturated 8-bit output per neuron. It replaces a bank of fully parallel node instances when area matters more than throughput.

## Interface
Parameters:
- N_IN, 15, inputs per neuron (≥2)
- N_OUT, 32, neurons per layer (≥1)
- ACC_W, 23, accumulator width (signed)
- FRAC_SHIFT, 6, requantization right shift

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the cycle done is high, inclusive
- act_addr  out  $clog2(N_IN)  activation buffer read address
- act_data  in  8  signed activation; valid 1 cycle after its address
- w_addr  out  $clog2(N_IN*N_OUT)  weight ROM address, n*N_IN+k
- w_data  in  8  signed weight; valid 1 cycle after its address
- b_addr  out  $clog2(N_OUT)  bias ROM address
- b_data  in  16  signed bias; valid 1 cycle after its address
- out_valid  out  1  one-cycle pulse per neuron
- out_idx  out  $clog2(N_OUT)  neuron index of out_data
- out_data  out  8  quantized output
- done  out  1  pulses together with the final out_valid

Reset values: busy=0, out_valid=0, done=0, out_idx=0, out_data=0, all addresses=0, FSM=IDLE, acc=0.

## Operation
- FSM states: IDLE, BIAS, MAC, QUANT.
- IDLE:
  - start=1 → BIAS, with n=0.
  - start while not in IDLE is ignored.
- BIAS (1 cycle):
  - b_addr=n, w_addr=n*N_IN, act_addr=0.
  - → MAC with k=0.
- MAC (N_IN cycles, k=0..N_IN-1):
  - prod = act_data*w_data, signed 16-bit, sign-extended to ACC_W.
  - k=0: acc ← sext(b_data)+prod. k>0: acc ← acc+prod.
  - When k<N_IN-1, issue addresses k+1 in the same cycle.
  - After k=N_IN-1 → QUANT.
- QUANT (1 cycle): registers out_data, out_idx=n, out_valid=1; all are visible the next cycle.
  - n<N_OUT-1 → BIAS with n+1.
  - Otherwise done=1 with that out_valid, and → IDLE.
- Quantization, with r = acc[FRAC_SHIFT+6:FRAC_SHIFT] + acc[FRAC_SHIFT-1] computed in 8 bits:
  - acc[ACC_W-1]=1 → 0.
  - Otherwise, if acc[ACC_W-2:FRAC_SHIFT+7]≠0 or r>127 → 127.
  - Otherwise → r.
  - Output is always in 0..127.
- Accumulator wrap is not detected. ACC_W must be ≥ 17+$clog2(N_IN+1) for the parameters chosen.

## Timing
- start sampled at edge 0 → BIAS during cycle 1, MAC during cycles 2..N_IN+1, QUANT during cycle N_IN+2.
- Neuron n: out_valid high in cycle (n+1)*(N_IN+2)+1. The default first output is at cycle 18, stride 17.
- done is high in cycle N_OUT*(N_IN+2)+1 (545 by default). The FSM is in IDLE that same cycle, so start may be accepted there.
- No output backpressure; the consumer must accept every out_valid.
- Reset at any cycle aborts the layer and returns all outputs to reset values on the next edge. No partial output is emitted.
- Memory contents must be stable while busy=1.

## Structure
- Shared package nn_quant_pkg holds:
  - ACC_W and FRAC_SHIFT defaults
  - the FSM state enum
  - a quantize function, reused by the parallel node generators.
- Sub-module mac_unit: registered signed 8x8 multiply-accumulate with load_bias/accumulate controls and ACC_W output. The FSM and address counters stay in layer_seq_ctrl.

## Test plan
- Bias −1024, all activations 0 → every out_data=0, N_OUT pulses, done coincident with out_idx=N_OUT−1.
- Bias 0, activations all 64, weights all 1 (acc=960) → out_data=15 for every neuron; first out_valid at cycle 18.
- Bias 32, activations 0 → acc=32, rounding bit set → out_data=1.
- Activations 127, weights 127, bias 0 (acc=241935) → out_data=127. A second case has activations −1, weights 1 (acc=−15) → 0.
- start held high continuously → layers run back-to-back; the second layer's out_idx=0 pulse is at cycle 545+18. Pulses of start mid-layer are ignored.
- reset asserted in MAC of neuron 3 → next cycle busy=0, out_valid=0, no out_idx=3 output. A fresh start then reproduces the full sequence from neuron 0.
